// File: rtl/pid_controller_mc.sv
// Shared-datapath PID controller: one ERR/MUL/ACC/SAT pipeline walks all channels per update edge.
// Per-channel gains, limits, mode and enable live in an internal register file.
module pid_controller_mc #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int GAIN_W    = 16,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       update,
  input  logic [NUM_CH*DATA_W-1:0]   sp,
  input  logic [NUM_CH*DATA_W-1:0]   position,
  input  logic [NUM_CH*DATA_W-1:0]   velocity,
  input  logic [NUM_CH*DATA_W-1:0]   displacement,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_ch,
  input  logic [3:0]                 cfg_addr,
  input  logic [31:0]                cfg_data,
  output logic [NUM_CH*OUT_W-1:0]    result,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);
  // state | meaning
  // IDLE  | waiting for an update rising edge
  // ERR   | err = sat(sp - pv) for channel ch
  // MUL   | p, d and ff products
  // ACC   | integral update with deadband and anti-windup
  // SAT   | clamp and write result, advance channel
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW = DATA_W + GAIN_W;
  localparam int PW = DATA_W + GAIN_W + 1;
  localparam int SW = DATA_W + GAIN_W + 3;
  localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_ACC, S_SAT} state_t;

  state_t                    state_q, state_d;
  logic                      update_prev_q, update_prev_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic                      busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic signed [DATA_W-1:0]  sp_snap_q [NUM_CH], sp_snap_d [NUM_CH];
  logic signed [DATA_W-1:0]  pv_snap_q [NUM_CH], pv_snap_d [NUM_CH];
  logic signed [DATA_W-1:0]  err_q, err_d;
  logic signed [PW-1:0]      p_q, p_d, d_q, d_d, ff_q, ff_d;
  logic signed [IW-1:0]      integ_q [NUM_CH], integ_d [NUM_CH];
  logic signed [DATA_W-1:0]  last_err_q [NUM_CH], last_err_d [NUM_CH];
  logic signed [OUT_W-1:0]   result_q [NUM_CH], result_d [NUM_CH];
  logic [GAIN_W-1:0]         kp_q [NUM_CH], kp_d [NUM_CH], ki_q [NUM_CH], ki_d [NUM_CH];
  logic [GAIN_W-1:0]         kd_q [NUM_CH], kd_d [NUM_CH], kf_q [NUM_CH], kf_d [NUM_CH];
  logic [GAIN_W-1:0]         db_q [NUM_CH], db_d [NUM_CH];
  logic signed [OUT_W-1:0]   out_pos_q [NUM_CH], out_pos_d [NUM_CH], out_neg_q [NUM_CH], out_neg_d [NUM_CH];
  logic signed [OUT_W-1:0]   int_pos_q [NUM_CH], int_pos_d [NUM_CH], int_neg_q [NUM_CH], int_neg_d [NUM_CH];
  logic [1:0]                mode_q [NUM_CH], mode_d [NUM_CH];
  logic [NUM_CH-1:0]         en_q, en_d;

  logic                      rise, in_db, p_ok;
  logic signed [DATA_W:0]    diff, err_x1, abs_err;
  logic signed [PW-1:0]      err_x, ki_prod;
  logic signed [SW-1:0]      sum, isum;

  // Negative bound applied first so that the positive bound wins on inverted limits.
  function automatic logic signed [SW-1:0] clamp(input logic signed [SW-1:0] x,
                                                 input logic signed [OUT_W-1:0] lo,
                                                 input logic signed [OUT_W-1:0] hi);
    logic signed [SW-1:0] y;
    y = x;
    if (y < SW'(lo)) y = SW'(lo);
    if (y > SW'(hi)) y = SW'(hi);
    return y;
  endfunction

  function automatic logic signed [PW-1:0] gain(input logic [GAIN_W-1:0] g);
    return PW'($signed({1'b0, g}));
  endfunction

  always_comb begin
    state_d = state_q;  ch_d = ch_q;  update_prev_d = update;
    busy_d = busy_q;  done_d = 1'b0;
    sp_snap_d = sp_snap_q;  pv_snap_d = pv_snap_q;
    err_d = err_q;  p_d = p_q;  d_d = d_q;  ff_d = ff_q;
    integ_d = integ_q;  last_err_d = last_err_q;  result_d = result_q;
    kp_d = kp_q;  ki_d = ki_q;  kd_d = kd_q;  kf_d = kf_q;  db_d = db_q;
    out_pos_d = out_pos_q;  out_neg_d = out_neg_q;
    int_pos_d = int_pos_q;  int_neg_d = int_neg_q;
    mode_d = mode_q;  en_d = en_q;

    rise      = update & ~update_prev_q;
    overrun_d = rise && (state_q != S_IDLE);
    err_x     = PW'(err_q);
    err_x1    = (DATA_W+1)'(err_q);
    abs_err   = (err_x1 < 0) ? -err_x1 : err_x1;
    in_db     = abs_err <= $signed((DATA_W+1)'(db_q[ch_q]));
    p_ok      = (p_q >= PW'(out_neg_q[ch_q])) && (p_q <= PW'(out_pos_q[ch_q]));
    ki_prod   = (gain(ki_q[ch_q]) * err_x) >>> FRAC_BITS;
    isum      = SW'(integ_q[ch_q]) + SW'(ki_prod);
    sum       = SW'(ff_q) + SW'(p_q) + SW'(integ_q[ch_q]) + SW'(d_q);
    diff      = (DATA_W+1)'(sp_snap_q[ch_q]) - (DATA_W+1)'(pv_snap_q[ch_q]);

    if (cfg_we && ({1'b0, cfg_ch} < NUM_CH_L)) begin
      case (cfg_addr)
        4'd0:  kp_d[cfg_ch[CW-1:0]]      = cfg_data[GAIN_W-1:0];
        4'd1:  ki_d[cfg_ch[CW-1:0]]      = cfg_data[GAIN_W-1:0];
        4'd2:  kd_d[cfg_ch[CW-1:0]]      = cfg_data[GAIN_W-1:0];
        4'd3:  kf_d[cfg_ch[CW-1:0]]      = cfg_data[GAIN_W-1:0];
        4'd4:  db_d[cfg_ch[CW-1:0]]      = cfg_data[GAIN_W-1:0];
        4'd5:  out_pos_d[cfg_ch[CW-1:0]] = cfg_data[OUT_W-1:0];
        4'd6:  out_neg_d[cfg_ch[CW-1:0]] = cfg_data[OUT_W-1:0];
        4'd7:  int_pos_d[cfg_ch[CW-1:0]] = cfg_data[OUT_W-1:0];
        4'd8:  int_neg_d[cfg_ch[CW-1:0]] = cfg_data[OUT_W-1:0];
        4'd9:  mode_d[cfg_ch[CW-1:0]]    = cfg_data[1:0];
        4'd10: en_d[cfg_ch[CW-1:0]]      = cfg_data[0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: if (rise) begin
        state_d = S_ERR;
        ch_d    = '0;
        busy_d  = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          sp_snap_d[i] = sp[i*DATA_W +: DATA_W];
          case (mode_q[i])
            2'd0:    pv_snap_d[i] = position[i*DATA_W +: DATA_W];
            2'd1:    pv_snap_d[i] = velocity[i*DATA_W +: DATA_W];
            2'd2:    pv_snap_d[i] = displacement[i*DATA_W +: DATA_W];
            default: pv_snap_d[i] = sp[i*DATA_W +: DATA_W];
          endcase
        end
      end
      S_ERR: begin
        if (diff[DATA_W] != diff[DATA_W-1])
          err_d = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
          err_d = diff[DATA_W-1:0];
        state_d = S_MUL;
      end
      S_MUL: begin
        p_d  = (gain(kp_q[ch_q]) * err_x) >>> FRAC_BITS;
        d_d  = (gain(kd_q[ch_q]) * (err_x - PW'(last_err_q[ch_q]))) >>> FRAC_BITS;
        ff_d = (gain(kf_q[ch_q]) * PW'(sp_snap_q[ch_q])) >>> FRAC_BITS;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (!en_q[ch_q])
          integ_d[ch_q] = '0;
        else if (!in_db && p_ok)
          integ_d[ch_q] = IW'(clamp(isum, int_neg_q[ch_q], int_pos_q[ch_q]));
        state_d = S_SAT;
      end
      S_SAT: begin
        if (!en_q[ch_q]) begin
          result_d[ch_q]   = '0;
          integ_d[ch_q]    = '0;
          last_err_d[ch_q] = '0;
        end else begin
          result_d[ch_q] = in_db ? OUT_W'(clamp(SW'(integ_q[ch_q]), out_neg_q[ch_q], out_pos_q[ch_q]))
                                 : OUT_W'(clamp(sum, out_neg_q[ch_q], out_pos_q[ch_q]));
          last_err_d[ch_q] = err_q;
        end
        if (ch_q == CW'(NUM_CH-1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  ch_q <= '0;  update_prev_q <= 1'b0;
      busy_q <= 1'b0;  done_q <= 1'b0;  overrun_q <= 1'b0;
      sp_snap_q <= '{default: '0};  pv_snap_q <= '{default: '0};
      err_q <= '0;  p_q <= '0;  d_q <= '0;  ff_q <= '0;
      integ_q <= '{default: '0};  last_err_q <= '{default: '0};  result_q <= '{default: '0};
      kp_q <= '{default: '0};  ki_q <= '{default: '0};  kd_q <= '{default: '0};
      kf_q <= '{default: '0};  db_q <= '{default: '0};
      out_pos_q <= '{default: '0};  out_neg_q <= '{default: '0};
      int_pos_q <= '{default: '0};  int_neg_q <= '{default: '0};
      mode_q <= '{default: '0};  en_q <= '0;
    end else begin
      state_q <= state_d;  ch_q <= ch_d;  update_prev_q <= update_prev_d;
      busy_q <= busy_d;  done_q <= done_d;  overrun_q <= overrun_d;
      sp_snap_q <= sp_snap_d;  pv_snap_q <= pv_snap_d;
      err_q <= err_d;  p_q <= p_d;  d_q <= d_d;  ff_q <= ff_d;
      integ_q <= integ_d;  last_err_q <= last_err_d;  result_q <= result_d;
      kp_q <= kp_d;  ki_q <= ki_d;  kd_q <= kd_d;  kf_q <= kf_d;  db_q <= db_d;
      out_pos_q <= out_pos_d;  out_neg_q <= out_neg_d;
      int_pos_q <= int_pos_d;  int_neg_q <= int_neg_d;
      mode_q <= mode_d;  en_q <= en_d;
    end
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_CH; i++) result[i*OUT_W +: OUT_W] = result_q[i];
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
